// File: rtl/gmii_pkg.sv
// Shared GMII types for the TX-side frame checker.
// One struct carries the enable, error and data lines of the bus.
package gmii_pkg;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] data;
  } GmiiBus;

endpackage

// File: rtl/gmii_frame_checker.sv
// GMII TX frame checker: strips preamble/SFD, checks FCS, length and IFG,
// and emits a per-frame verdict strobe plus running counters.
module gmii_frame_checker
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int MIN_IFG       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  GmiiBus      gmii_bus,
  input  logic        clear,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_len,
  output logic        err_crc,
  output logic        err_runt,
  output logic        err_giant,
  output logic        err_gmii,
  output logic        err_preamble,
  output logic        err_ifg,
  output logic [31:0] count_ok,
  output logic [31:0] count_bad,
  output logic [31:0] count_bytes
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [15:0] LP_MIN  = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] LP_MAX  = 16'(MAX_FRAME_LEN);
  localparam logic [15:0] LP_IFG  = 16'(MIN_IFG);

  logic [1:0]  r_state;
  logic        r_en_d;
  logic [15:0] r_ifg;
  logic [3:0]  r_pre_cnt;
  logic [15:0] r_len;
  logic [31:0] r_crc;
  logic        r_e_pre;
  logic        r_e_gmii;
  logic        r_e_ifg;

  logic        w_en;
  logic        w_er;
  logic [7:0]  w_data;
  logic        w_idle;
  logic        w_rise;
  logic        w_end;
  logic        w_pre_step;
  logic        w_body;
  logic        w_disc;
  logic [3:0]  w_cnt;
  logic        w_sfd;
  logic        w_more;
  logic        w_v_pre;
  logic        w_v_crc;
  logic        w_v_runt;
  logic        w_v_giant;
  logic        w_v_any;

  function automatic logic [31:0] f_crc8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 8; i++) begin
      if (v[0] ^ d[i]) v = (v >> 1) ^ POLY;
      else             v = v >> 1;
    end
    return v;
  endfunction

  assign w_en   = gmii_bus.en;
  assign w_er   = gmii_bus.er;
  assign w_data = gmii_bus.data;

  // r_en_d resets high so a frame in flight at reset release is no edge
  assign w_idle     = (r_state == S_IDLE);
  assign w_rise     = w_idle & w_en & ~r_en_d;
  assign w_end      = ~w_idle & ~w_en;
  assign w_pre_step = w_rise | (w_en & (r_state == S_PRE));
  assign w_body     = w_en & (r_state == S_BODY);
  assign w_disc     = w_en & (r_state == S_DISC);

  assign w_cnt  = w_idle ? 4'd0 : r_pre_cnt;
  assign w_sfd  = (w_data == 8'hD5) && (w_cnt != 4'd0) && (w_cnt <= 4'd7);
  assign w_more = (w_data == 8'h55) && (w_cnt < 4'd7);

  // a frame that ends without reaching SFD is a preamble failure
  assign w_v_pre   = r_e_pre | (r_state == S_PRE);
  assign w_v_crc   = ~w_v_pre & (r_crc != RESIDUE);
  assign w_v_runt  = ~w_v_pre & (r_len < LP_MIN);
  assign w_v_giant = ~w_v_pre & (r_len > LP_MAX);
  assign w_v_any   = w_v_pre | w_v_crc | w_v_runt | w_v_giant
                   | r_e_gmii | r_e_ifg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_en_d       <= 1'b1;
      r_ifg        <= LP_IFG;
      r_pre_cnt    <= 4'd0;
      r_len        <= 16'd0;
      r_crc        <= 32'hFFFFFFFF;
      r_e_pre      <= 1'b0;
      r_e_gmii     <= 1'b0;
      r_e_ifg      <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_len    <= 16'd0;
      err_crc      <= 1'b0;
      err_runt     <= 1'b0;
      err_giant    <= 1'b0;
      err_gmii     <= 1'b0;
      err_preamble <= 1'b0;
      err_ifg      <= 1'b0;
    end else begin
      r_en_d     <= w_en;
      frame_done <= 1'b0;
      if (w_en)                r_ifg <= 16'd0;
      else if (r_ifg < LP_IFG) r_ifg <= r_ifg + 16'd1;
      unique case (1'b1)
        w_end: begin
          frame_done   <= 1'b1;
          frame_ok     <= ~w_v_any;
          frame_len    <= r_len;
          err_crc      <= w_v_crc;
          err_runt     <= w_v_runt;
          err_giant    <= w_v_giant;
          err_gmii     <= r_e_gmii;
          err_preamble <= w_v_pre;
          err_ifg      <= r_e_ifg;
          r_state      <= S_IDLE;
        end
        w_pre_step: begin
          if (w_rise) begin
            r_e_ifg  <= (r_ifg < LP_IFG);
            r_e_gmii <= w_er;
            r_e_pre  <= 1'b0;
            r_len    <= 16'd0;
            r_crc    <= 32'hFFFFFFFF;
          end else begin
            r_e_gmii <= r_e_gmii | w_er;
          end
          if (w_sfd) begin
            r_state <= S_BODY;
          end else if (w_more) begin
            r_pre_cnt <= w_cnt + 4'd1;
            r_state   <= S_PRE;
          end else begin
            r_e_pre <= 1'b1;
            r_state <= S_DISC;
          end
        end
        w_body: begin
          r_crc    <= f_crc8(r_crc, w_data);
          r_e_gmii <= r_e_gmii | w_er;
          if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
        end
        w_disc: begin
          r_e_gmii <= r_e_gmii | w_er;
        end
        default: ;
      endcase
    end
  end

  // counters follow the registered verdict; clear on that cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_ok    <= 32'd0;
      count_bad   <= 32'd0;
      count_bytes <= 32'd0;
    end else if (clear) begin
      count_ok    <= 32'd0;
      count_bad   <= 32'd0;
      count_bytes <= 32'd0;
    end else if (frame_done) begin
      if (frame_ok) begin
        if (count_ok != 32'hFFFFFFFF) count_ok <= count_ok + 32'd1;
      end else begin
        if (count_bad != 32'hFFFFFFFF) count_bad <= count_bad + 32'd1;
      end
      count_bytes <= count_bytes + {16'd0, frame_len};
    end
  end

endmodule

// File: tb/tb_gmii_frame_checker.sv
// Scoreboard bench for gmii_frame_checker: directed frames push expected
// verdicts and counters; a monitor pops and compares on each frame_done.
module tb_gmii_frame_checker;
  import gmii_pkg::*;

  localparam bit [5:0] F_CRC   = 6'b100000;
  localparam bit [5:0] F_RUNT  = 6'b010000;
  localparam bit [5:0] F_GIANT = 6'b001000;
  localparam bit [5:0] F_GMII  = 6'b000100;
  localparam bit [5:0] F_PRE   = 6'b000010;
  localparam bit [5:0] F_IFG   = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  GmiiBus      bus;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_len;
  logic        err_crc;
  logic        err_runt;
  logic        err_giant;
  logic        err_gmii;
  logic        err_preamble;
  logic        err_ifg;
  logic [31:0] count_ok;
  logic [31:0] count_bad;
  logic [31:0] count_bytes;

  always #5 clk = ~clk;

  gmii_frame_checker dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_bus     (bus),
    .clear        (clear),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .frame_len    (frame_len),
    .err_crc      (err_crc),
    .err_runt     (err_runt),
    .err_giant    (err_giant),
    .err_gmii     (err_gmii),
    .err_preamble (err_preamble),
    .err_ifg      (err_ifg),
    .count_ok     (count_ok),
    .count_bad    (count_bad),
    .count_bytes  (count_bytes)
  );

  typedef struct {
    bit          ok;
    int          len;
    bit [5:0]    flg;
    int unsigned cok;
    int unsigned cbad;
    int unsigned cbytes;
  } exp_t;

  exp_t         q[$];
  byte unsigned fr[$];
  int unsigned  m_ok;
  int unsigned  m_bad;
  int unsigned  m_bytes;
  int           checks = 0;
  int           failures = 0;
  bit           mon_busy = 1'b0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 8; i++)
      v = (v[0] ^ d[i]) ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  // 7x 0x55, SFD, nd data bytes, FCS sent LSB byte first
  task automatic mk_frame(input int nd);
    logic [31:0] c;
    byte unsigned b;
    fr.delete();
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nd; i++) begin
      b = 8'(i * 13 + 5);
      fr.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  task automatic expect_frame(input int len, input bit [5:0] flg, input bit clr);
    exp_t e;
    e.ok  = (flg == 6'b0);
    e.len = len;
    e.flg = flg;
    if (clr) begin
      m_ok = 0;
      m_bad = 0;
      m_bytes = 0;
    end else begin
      if (e.ok) m_ok++;
      else      m_bad++;
      m_bytes += len;
    end
    e.cok    = m_ok;
    e.cbad   = m_bad;
    e.cbytes = m_bytes;
    q.push_back(e);
  endtask

  task automatic send(input int er_at, input int idle, input int clr_at,
                      input int rst_at, input int er_idle_at);
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk);
      #1;
      bus.en   = 1'b1;
      bus.er   = (i == er_at);
      bus.data = fr[i];
      if (i == rst_at)     rst = 1'b1;
      if (i == rst_at + 2) rst = 1'b0;
    end
    for (int k = 0; k < idle; k++) begin
      @(posedge clk);
      #1;
      bus    = '0;
      bus.er = (k == er_idle_at);
      clear  = (k == clr_at);
    end
    clear = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && frame_done) begin
        mon_busy = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_frame_done", frame_done, 0);
        end else begin
          e = q.pop_front();
          chk("frame_ok", frame_ok, e.ok);
          chk("frame_len", frame_len, e.len);
          chk("err_flags", {err_crc, err_runt, err_giant,
                            err_gmii, err_preamble, err_ifg}, e.flg);
          @(negedge clk);
          chk("done_pulse", frame_done, 0);
          chk("count_ok", count_ok, e.cok);
          chk("count_bad", count_bad, e.cbad);
          chk("count_bytes", count_bytes, e.cbytes);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    bus   = '0;
    m_ok = 0;
    m_bad = 0;
    m_bytes = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_err_flags", {err_crc, err_runt, err_giant,
                          err_gmii, err_preamble, err_ifg}, 0);
    chk("rst_counters", {count_ok, count_bad, count_bytes}, 0);
    repeat (4) @(posedge clk);

    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 12, -1, -1, -1);
    mk_frame(60);   fr[fr.size() - 1] ^= 8'h01;
                    expect_frame(64, F_CRC, 0);   send(-1, 12, -1, -1, -1);
    mk_frame(52);   expect_frame(56, F_RUNT, 0);  send(-1, 12, -1, -1, -1);
    mk_frame(1519); expect_frame(1523, F_GIANT, 0); send(-1, 12, -1, -1, -1);
    mk_frame(1518); expect_frame(1522, 6'b0, 0);  send(-1, 12, -1, -1, -1);
    mk_frame(60);   expect_frame(64, F_GMII, 0);  send(28, 12, -1, -1, -1);
    mk_frame(60);   fr[1] = 8'h54;
                    expect_frame(0, F_PRE, 0);    send(-1, 12, -1, -1, -1);
    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 8, -1, -1, -1);
    mk_frame(60);   expect_frame(64, F_IFG, 0);   send(-1, 12, -1, -1, -1);
    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 12, -1, -1, 0);
    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 12, -1, -1, -1);
    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 1, -1, -1, -1);
    mk_frame(60);   expect_frame(64, F_IFG, 0);   send(-1, 12, -1, -1, -1);
    mk_frame(60);   expect_frame(64, 6'b0, 1);    send(-1, 12, 1, -1, -1);
    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 12, -1, -1, -1);

    // reset mid-body with en held high, then one clean frame
    m_ok = 0;
    m_bad = 0;
    m_bytes = 0;
    mk_frame(60);   send(-1, 12, -1, 38, -1);
    mk_frame(60);   expect_frame(64, 6'b0, 0);    send(-1, 12, -1, -1, -1);

    repeat (5) @(negedge clk);
    for (int t = 0; t < 200 && (q.size() != 0 || mon_busy); t++)
      @(negedge clk);
    chk("pending_verdicts", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
